scan_scheduler: RTL

//  Sequences two scanner channels, each backed by an occupancy counter (scan: +1 up to
//  CAP; flush: -3 when >2, else -1), so that scanning never stalls.
//  One channel scans while the other stands by. On fill, the channels hand off.
//  The full channel then drains over a single shared uplink, with a req/gnt handshake.

---
 rtl/scan_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/scan_scheduler.sv
// Ping-pong scheduler for two occupancy-counted scanner channels sharing one uplink.
// Per-channel FSMs live in scan_chan; the top module handles handoff, overrun and uplink ownership.

module scan_chan #(
  parameter int CAP = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mem_used,
  input  logic       go,
  input  logic       stop,
  input  logic       own,
  input  logic       xfer_gnt,
  output logic       scan,
  output logic       flush,
  output logic       is_idle,
  output logic       is_scan,
  output logic       is_wait,
  output logic       to_wait,
  output logic       done
);
  localparam logic [7:0] CAP_W = 8'(CAP);

  typedef enum logic [1:0] {IDLE, SCAN, WAITX, FLUSH} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go)                          state_nxt = SCAN;
      SCAN:    if (stop || mem_used == CAP_W)   state_nxt = WAITX;
      WAITX:   if (own && xfer_gnt)             state_nxt = FLUSH;
      FLUSH:   if (mem_used == 8'd0)            state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  assign is_idle = (state == IDLE);
  assign is_scan = (state == SCAN);
  assign is_wait = (state == WAITX);
  assign to_wait = is_scan && (stop || mem_used == CAP_W);
  assign done    = (state == FLUSH) && (mem_used == 8'd0);
  // Gate on occupancy so the counter never overshoots CAP or underflows.
  assign scan    = is_scan && (mem_used < CAP_W);
  assign flush   = (state == FLUSH) && xfer_gnt && (mem_used != 8'd0);
endmodule

module scan_scheduler #(
  parameter int CAP      = 100,
  parameter int STBY_LVL = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] mem_used0,
  input  logic [7:0] mem_used1,
  output logic       scan0,
  output logic       flush0,
  output logic       scan1,
  output logic       flush1,
  output logic       standby0,
  output logic       standby1,
  output logic       xfer_req,
  output logic       xfer_ch,
  input  logic       xfer_gnt,
  output logic       busy,
  output logic       overrun
);
  localparam int NCH = 2;
  localparam logic [7:0] CAP_W  = 8'(CAP);
  localparam logic [7:0] STBY_W = 8'(STBY_LVL);

  logic [NCH-1:0][7:0] mem;
  logic [NCH-1:0] go, own, scan, flush, is_idle, is_scan, is_wait, to_wait, done;
  logic [NCH-1:0] idle_empty, cap_hit, standby;
  logic session, pend, owner_vld, owner;
  logic start_ok, resume, overrun_set, release_own;

  assign mem = {mem_used1, mem_used0};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign own[i]        = owner_vld && (owner == 1'(i));
    assign idle_empty[i] = is_idle[i] && (mem[i] == 8'd0);
    assign cap_hit[i]    = is_scan[i] && (mem[i] == CAP_W) && !stop;
    assign standby[i]    = idle_empty[i] && is_scan[1-i] && (mem[1-i] >= STBY_W);

    scan_chan #(.CAP(CAP)) u_chan (
      .clk(clk), .reset(reset), .mem_used(mem[i]), .go(go[i]), .stop(stop),
      .own(own[i]), .xfer_gnt(xfer_gnt), .scan(scan[i]), .flush(flush[i]),
      .is_idle(is_idle[i]), .is_scan(is_scan[i]), .is_wait(is_wait[i]),
      .to_wait(to_wait[i]), .done(done[i])
    );
  end

  assign start_ok    = start && !stop && (&idle_empty);
  // After an overrun, whichever channel comes back IDLE first (ch0 on a tie) restarts scanning.
  assign resume      = pend && session && !stop;
  assign go[0]       = start_ok || (cap_hit[1] && idle_empty[0]) || (resume && idle_empty[0]);
  assign go[1]       = (cap_hit[0] && idle_empty[1]) || (resume && idle_empty[1] && !idle_empty[0]);
  assign overrun_set = (cap_hit[0] && !idle_empty[1]) || (cap_hit[1] && !idle_empty[0]);
  assign release_own = owner_vld && done[owner];

  always_ff @(posedge clk) begin
    if (reset) begin
      session <= 1'b0;
      overrun <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (stop)          session <= 1'b0;
      else if (start_ok) session <= 1'b1;
      if (start_ok)         overrun <= 1'b0;
      else if (overrun_set) overrun <= 1'b1;
      if (stop || start_ok || (resume && |idle_empty)) pend <= 1'b0;
      else if (overrun_set)                            pend <= 1'b1;
    end
  end

  // Channels already waiting outrank ones entering WAITX this cycle; ch0 wins ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_vld <= 1'b0;
      owner     <= 1'b0;
    end else if (!owner_vld || release_own) begin
      owner_vld <= 1'b1;
      if (is_wait[0])      owner <= 1'b0;
      else if (is_wait[1]) owner <= 1'b1;
      else if (to_wait[0]) owner <= 1'b0;
      else if (to_wait[1]) owner <= 1'b1;
      else                 owner_vld <= 1'b0;
    end
  end

  assign scan0    = scan[0];
  assign scan1    = scan[1];
  assign flush0   = flush[0];
  assign flush1   = flush[1];
  assign standby0 = standby[0];
  assign standby1 = standby[1];
  assign xfer_req = owner_vld;
  assign xfer_ch  = owner;
  assign busy     = session || !(&is_idle);
endmodule
